// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding and elaboration-time helper functions.
package bin_to_bcd_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Largest value representable in the given number of BCD digits (10^d - 1).
   function automatic int pow10_minus1(input int digits);
      int p;
      p = 1;
      for (int i = 0; i < digits; i++) begin
         p = p * 10;
      end
      return p - 1;
   endfunction

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj (
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one input bit per clock, with a
// start/busy/done handshake and a held, saturating BCD result for the display.
module bin_to_bcd_seq
   import bin_to_bcd_seq_pkg::*;
#(
   parameter int BIN_W  = 7,
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst_N,
   input  logic                  start,
   input  logic [BIN_W-1:0]      number_bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   number_BCD,
   output logic                  valid,
   output logic                  overflow
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = clog2(BIN_W + 1);
   localparam int MAX   = pow10_minus1(DIGITS);
   localparam logic [BCD_W-1:0] NINES = {DIGITS{4'h9}};

   state_e             r_state;
   state_e             w_state_next;
   logic [BIN_W-1:0]   r_shift;
   logic [BCD_W-1:0]   r_scratch;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ovf_pend;
   logic [BCD_W-1:0]   r_bcd;
   logic               r_valid;
   logic               r_overflow;

   logic               w_accept;
   logic               w_last;
   logic               w_ovf;
   logic [31:0]        w_bin_ext;
   logic [BCD_W-1:0]   w_adj;
   logic [BCD_W-1:0]   w_scratch_next;

   // Each digit is corrected before the shift, all in the same cycle.
   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_adj
         bcd_digit_adj u_adj (
            .i_digit (r_scratch[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
         );
      end
   endgenerate

   assign w_scratch_next = {w_adj[BCD_W-2:0], r_shift[BIN_W-1]};
   assign w_bin_ext      = 32'(number_bin);
   assign w_ovf          = (w_bin_ext > 32'(MAX));
   assign w_accept       = (r_state != ST_SHIFT) && start;
   assign w_last         = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(1));

   always_ff @(posedge clk or negedge rst_N) begin
      if (!rst_N) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         ST_IDLE,
         ST_DONE: begin
            done         = (r_state == ST_DONE);
            w_state_next = start ? ST_SHIFT : ST_IDLE;
         end
         ST_SHIFT: begin
            busy         = 1'b1;
            w_state_next = w_last ? ST_DONE : ST_SHIFT;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // The result is registered on the final shift edge so it changes
   // exactly when done rises and is held until the next completion.
   always_ff @(posedge clk or negedge rst_N) begin
      if (!rst_N) begin
         r_shift    <= '0;
         r_scratch  <= '0;
         r_cnt      <= '0;
         r_ovf_pend <= 1'b0;
         r_bcd      <= '0;
         r_valid    <= 1'b0;
         r_overflow <= 1'b0;
      end else if (w_accept) begin
         r_shift    <= number_bin;
         r_scratch  <= '0;
         r_cnt      <= CNT_W'(BIN_W);
         r_ovf_pend <= w_ovf;
      end else if (r_state == ST_SHIFT) begin
         r_scratch <= w_scratch_next;
         r_shift   <= r_shift << 1;
         r_cnt     <= r_cnt - CNT_W'(1);
         if (w_last) begin
            r_bcd      <= r_ovf_pend ? NINES : w_scratch_next;
            r_overflow <= r_ovf_pend;
            r_valid    <= 1'b1;
         end
      end
   end

   assign number_BCD = r_bcd;
   assign valid      = r_valid;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomised self-checking bench for bin_to_bcd_seq against a decimal
// arithmetic reference model.
module tb_bin_to_bcd_seq;

   localparam int BIN_W  = 7;
   localparam int DIGITS = 2;
   localparam int LAT    = BIN_W + 1;

   logic                clk;
   logic                rst_N;
   logic                start;
   logic [BIN_W-1:0]    number_bin;
   logic                busy;
   logic                done;
   logic [4*DIGITS-1:0] number_BCD;
   logic                valid;
   logic                overflow;

   int checks;
   int errors;

   bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk        (clk),
      .rst_N      (rst_N),
      .start      (start),
      .number_bin (number_bin),
      .busy       (busy),
      .done       (done),
      .number_BCD (number_BCD),
      .valid      (valid),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: decimal digits of n, saturated to 99 when n exceeds two digits.
   function automatic logic [8:0] model(input int n);
      if (n > 99) return {1'b1, 8'h99};
      return {1'b0, 4'(n / 10), 4'(n % 10)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts a conversion from the current cycle and waits for done (bounded).
   // lat counts edges from the accepting edge up to the one raising done.
   task automatic run_conv(input int n, output int lat, output int busy_cnt);
      number_bin = BIN_W'(n);
      start      = 1'b1;
      step();
      start      = 1'b0;
      number_bin = BIN_W'($urandom);
      lat        = 1;
      busy_cnt   = busy ? 1 : 0;
      while (!done && lat < 30) begin
         step();
         lat++;
         if (busy) busy_cnt++;
      end
   endtask

   task automatic test_reset();
      rst_N = 1'b0; start = 1'b0; number_bin = '0;
      step(); step();
      checks++;
      if ({busy, done, valid, overflow, number_BCD} !== 12'h000) begin
         errors++;
         $display("FAIL reset_hold got %h expected 000", {busy, done, valid, overflow, number_BCD});
      end
      rst_N = 1'b1;
      step();
      checks++;
      if ({busy, done, valid, overflow, number_BCD} !== 12'h000) begin
         errors++;
         $display("FAIL reset_release got %h expected 000", {busy, done, valid, overflow, number_BCD});
      end
   endtask

   task automatic test_basic();
      int lat, bc;
      run_conv(45, lat, bc);
      checks++;
      if (lat !== LAT || bc !== BIN_W) begin
         errors++;
         $display("FAIL basic_timing got lat=%0d busy=%0d expected lat=%0d busy=%0d", lat, bc, LAT, BIN_W);
      end
      checks++;
      if ({done, busy, valid, overflow, number_BCD} !== {4'b1010, 8'h45}) begin
         errors++;
         $display("FAIL basic_result got %h expected %h", {done, busy, valid, overflow, number_BCD}, {4'b1010, 8'h45});
      end
      step();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL basic_pulse got done=%b expected 0", done);
      end
   endtask

   task automatic test_bounds();
      int vals[5] = '{0, 99, 100, 127, 7};
      int lat, bc;
      logic [8:0] exp;
      foreach (vals[i]) begin
         run_conv(vals[i], lat, bc);
         exp = model(vals[i]);
         checks++;
         if ({overflow, number_BCD} !== exp || lat !== LAT) begin
            errors++;
            $display("FAIL bound_%0d got ovf/bcd=%h lat=%0d expected %h lat=%0d", vals[i], {overflow, number_BCD}, lat, exp, LAT);
         end
         step();
      end
   endtask

   task automatic test_ignore_start();
      int dones;
      number_bin = 7'd37; start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      number_bin = 7'd88; start = 1'b1;
      step();
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         if (done) begin
            dones++;
            checks++;
            if (number_BCD !== 8'h37) begin
               errors++;
               $display("FAIL ignore_result got %h expected 37", number_BCD);
            end
         end
         step();
      end
      checks++;
      if (dones !== 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore_dones got %0d busy=%b expected 1 busy=0", dones, busy);
      end
   endtask

   task automatic test_back_to_back();
      int lat, bc;
      run_conv(37, lat, bc);
      checks++;
      if (number_BCD !== 8'h37) begin
         errors++;
         $display("FAIL b2b_first got %h expected 37", number_BCD);
      end
      run_conv(12, lat, bc);
      checks++;
      if (number_BCD !== 8'h12 || lat !== LAT || overflow !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second got %h lat=%0d ovf=%b expected 12 lat=%0d ovf=0", number_BCD, lat, overflow, LAT);
      end
      step();
   endtask

   task automatic test_reset_abort();
      int lat, bc, dones;
      number_bin = 7'd63; start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      rst_N = 1'b0;
      #1;
      checks++;
      if ({busy, done, valid, overflow, number_BCD} !== 12'h000) begin
         errors++;
         $display("FAIL abort_outputs got %h expected 000", {busy, done, valid, overflow, number_BCD});
      end
      step();
      rst_N = 1'b1;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) dones++;
         step();
      end
      checks++;
      if (dones !== 0 || number_BCD !== 8'h00) begin
         errors++;
         $display("FAIL abort_nodone got dones=%0d bcd=%h expected 0 00", dones, number_BCD);
      end
      run_conv(21, lat, bc);
      checks++;
      if ({valid, overflow, number_BCD} !== {2'b10, 8'h21}) begin
         errors++;
         $display("FAIL abort_after got %h expected %h", {valid, overflow, number_BCD}, {2'b10, 8'h21});
      end
      step();
   endtask

   task automatic test_hold();
      int lat, bc, bad;
      run_conv(56, lat, bc);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         number_bin = BIN_W'($urandom);
         if (number_BCD !== 8'h56 || valid !== 1'b1) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL hold got %0d bad cycles bcd=%h valid=%b expected 0 56 1", bad, number_BCD, valid);
      end
   endtask

   task automatic test_random();
      int n, lat, bc;
      logic [8:0] exp;
      for (int i = 0; i < 25; i++) begin
         n   = $urandom_range(0, 127);
         exp = model(n);
         run_conv(n, lat, bc);
         checks++;
         if ({overflow, number_BCD} !== exp || lat !== LAT || valid !== 1'b1) begin
            errors++;
            $display("FAIL random_%0d got %h lat=%0d expected %h lat=%0d", n, {overflow, number_BCD}, lat, exp, LAT);
         end
         if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) step();
         end
      end
      step();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_bounds();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
      test_hold();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
